// File: rtl/sha256_digest_uart_tx_if.sv
// Digest-to-UART bundle between the SHA-256 core side and the UART transmitter.
// Carries the captured digest, its strobe, and the serial line with status flags.
interface sha256_digest_uart_tx_if;
    logic [255:0] sha_digest;
    logic         digest_valid;
    logic         tx;
    logic         busy;
    logic         tx_done;
    logic         overrun;

    modport master (
        output sha_digest,
        output digest_valid,
        input  tx,
        input  busy,
        input  tx_done,
        input  overrun
    );

    modport slave (
        input  sha_digest,
        input  digest_valid,
        output tx,
        output busy,
        output tx_done,
        output overrun
    );
endinterface

// File: rtl/sha256_digest_uart_tx.sv
// Serializes a captured 256-bit SHA-256 digest over an 8N1 UART line, LSB-first.
// Define SHA_DIGEST_HEX_ASCII_EN to send 64 lowercase hex characters plus CR LF instead of 32 raw bytes.
module sha256_digest_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                    clk,
    input  logic                    rst,
    sha256_digest_uart_tx_if.slave  bus
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // tx_done must be high during the final cycle of the last stop bit, so it is set one count early.
    localparam logic [CNT_W-1:0] BAUD_DONE = CNT_W'(CLKS_PER_BIT - 2);

`ifdef SHA_DIGEST_HEX_ASCII_EN
    localparam int CHAR_W = 7;
    localparam logic [CHAR_W-1:0] LAST_CHAR = 7'd65;
`else
    localparam int CHAR_W = 5;
    localparam logic [CHAR_W-1:0] LAST_CHAR = 5'd31;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

`ifdef SHA_DIGEST_HEX_ASCII_EN
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        logic [7:0] c;
        if (nib < 4'd10) begin
            c = {4'h3, nib};
        end else begin
            c = 8'h57 + {4'h0, nib};
        end
        return c;
    endfunction
`endif

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    baud_r, baud_s;
    logic [2:0]          bit_cnt_r, bit_cnt_s;
    logic [CHAR_W-1:0]   char_cnt_r, char_cnt_s;
    logic [255:0]        digest_sr_r, digest_sr_s;
    logic [7:0]          bit_sr_r, bit_sr_s;
    logic [7:0]          char_s;
    logic                load_s;
    logic                baud_wrap_s;
    logic                tx_r, tx_s;
    logic                busy_r, busy_s;
    logic                tx_done_r, tx_done_s;
    logic                overrun_r, overrun_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_s     = state_r;
        baud_s      = baud_r;
        bit_cnt_s   = bit_cnt_r;
        char_cnt_s  = char_cnt_r;
        digest_sr_s = digest_sr_r;
        bit_sr_s    = bit_sr_r;
        load_s      = 1'b0;
        char_s      = 8'h00;
        tx_s        = 1'b1;
        baud_wrap_s = (baud_r == BAUD_LAST);

        case (state_r)
            IDLE: begin
                baud_s = '0;
                if (bus.digest_valid) begin
                    state_s     = START;
                    digest_sr_s = bus.sha_digest;
                    char_cnt_s  = '0;
                    load_s      = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (baud_wrap_s) begin
                    baud_s    = '0;
                    bit_cnt_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap_s) begin
                    baud_s   = '0;
                    bit_sr_s = {1'b0, bit_sr_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap_s) begin
                    baud_s = '0;
                    if (char_cnt_r == LAST_CHAR) begin
                        state_s = IDLE;
                    end else begin
                        // Next frame follows the stop bit directly, no idle gap.
                        char_cnt_s  = char_cnt_r + CHAR_W'(1);
`ifdef SHA_DIGEST_HEX_ASCII_EN
                        digest_sr_s = {digest_sr_r[251:0], 4'h0};
`else
                        digest_sr_s = {digest_sr_r[247:0], 8'h00};
`endif
                        load_s      = 1'b1;
                        state_s     = START;
                    end
                end else begin
                    baud_s = baud_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                baud_s  = '0;
            end
        endcase

`ifdef SHA_DIGEST_HEX_ASCII_EN
        case (char_cnt_s)
            7'd64:   char_s = 8'h0D;
            7'd65:   char_s = 8'h0A;
            default: char_s = hex_char(digest_sr_s[255:252]);
        endcase
`else
        char_s = digest_sr_s[255:248];
`endif
        if (load_s) begin
            bit_sr_s = char_s;
        end else begin
            bit_sr_s = bit_sr_s;
        end

        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = bit_sr_s[0];
            default: tx_s = 1'b1;
        endcase

        busy_s    = (state_s != IDLE);
        tx_done_s = (state_r == STOP) && (char_cnt_r == LAST_CHAR) && (baud_r == BAUD_DONE);
        overrun_s = bus.digest_valid && (state_r != IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            baud_r      <= '0;
            bit_cnt_r   <= 3'd0;
            char_cnt_r  <= '0;
            digest_sr_r <= 256'd0;
            bit_sr_r    <= 8'h00;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            tx_done_r   <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            baud_r      <= baud_s;
            bit_cnt_r   <= bit_cnt_s;
            char_cnt_r  <= char_cnt_s;
            digest_sr_r <= digest_sr_s;
            bit_sr_r    <= bit_sr_s;
            tx_r        <= tx_s;
            busy_r      <= busy_s;
            tx_done_r   <= tx_done_s;
            overrun_r   <= overrun_s;
        end
    end

    assign bus.tx      = tx_r;
    assign bus.busy    = busy_r;
    assign bus.tx_done = tx_done_r;
    assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_sha256_digest_uart_tx.sv
// Directed/randomized bench for sha256_digest_uart_tx with a character-level reference model.
module tb_sha256_digest_uart_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef SHA_DIGEST_HEX_ASCII_EN
    localparam int NCHAR = 66;
    localparam logic [9:0] FIRST_FRAME = 10'b1_0110_0010_0;
`else
    localparam int NCHAR = 32;
    localparam logic [9:0] FIRST_FRAME = 10'b1_1011_1010_0;
`endif
    localparam int TOTAL = NCHAR * FRAME;
    localparam logic [255:0] KNOWN =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sha256_digest_uart_tx_if bus();

    sha256_digest_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_chars [NCHAR];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Character list the host should receive for a given digest.
    task automatic build_model(input logic [255:0] d);
        logic [255:0] t;
        int n;
`ifdef SHA_DIGEST_HEX_ASCII_EN
        for (int k = 0; k < 64; k++) begin
            t = d >> (252 - 4 * k);
            n = int'(t[3:0]);
            exp_chars[k] = (n < 10) ? 8'(8'h30 + n) : 8'(8'h61 + (n - 10));
        end
        exp_chars[64] = 8'h0D;
        exp_chars[65] = 8'h0A;
`else
        n = 0;
        for (int k = 0; k < 32; k++) begin
            t = d >> (248 - 8 * k);
            exp_chars[k] = t[7:0];
        end
`endif
    endtask

    task automatic rand_digest(output logic [255:0] d);
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom();
    endtask

    // Capture d, follow the whole line waveform; ovr_j is the cycle index where a stray digest_valid is raised.
    task automatic send_and_check(input logic [255:0] d, input int ovr_j, input string tag,
                                  output logic [9:0] first_fr);
        int lvl_err  = 0;
        int done_cnt = 0;
        int done_pos = -1;
        int ovr_cnt  = 0;
        int f, b;
        logic expbit;
        logic [9:0] fr;
        fr = 10'd0;
        first_fr = 10'd0;
        build_model(d);
        bus.sha_digest   = d;
        bus.digest_valid = 1'b1;
        tick();
        bus.digest_valid = 1'b0;
        check({tag, "_start_tx"}, 32'(bus.tx), 32'd0);
        check({tag, "_start_busy"}, 32'(bus.busy), 32'd1);
        for (int j = 0; j < TOTAL; j++) begin
            f = j / FRAME;
            b = (j % FRAME) / CPB;
            if (b == 0)      expbit = 1'b0;
            else if (b == 9) expbit = 1'b1;
            else             expbit = exp_chars[f][b-1];
            if (bus.tx !== expbit) lvl_err++;
            if (bus.busy !== 1'b1) lvl_err++;
            if (bus.tx_done === 1'b1) begin
                done_cnt++;
                done_pos = j;
            end
            if (bus.overrun === 1'b1) ovr_cnt++;
            if ((j % CPB) == CPB / 2) fr[b] = bus.tx;
            if ((j % FRAME) == FRAME - 1) begin
                check($sformatf("%s_frame%0d", tag, f), 32'(fr), 32'({1'b1, exp_chars[f], 1'b0}));
                if (f == 0) first_fr = fr;
            end
            bus.digest_valid = (j == ovr_j);
            bus.sha_digest   = (j == ovr_j) ? 256'd0 : d;
            tick();
        end
        bus.digest_valid = 1'b0;
        bus.sha_digest   = d;
        if (bus.overrun === 1'b1) ovr_cnt++;
        check({tag, "_line_errs"}, 32'(lvl_err), 32'd0);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_pos"}, 32'(done_pos), 32'(TOTAL - 1));
        check({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, "_tx_end"}, 32'(bus.tx), 32'd1);
        check({tag, "_done_end"}, 32'(bus.tx_done), 32'd0);
        check({tag, "_overruns"}, 32'(ovr_cnt), (ovr_j >= 0) ? 32'd1 : 32'd0);
    endtask

    logic [255:0] d;
    logic [9:0]   fr0;
    int idle_bad;
    int stray_done;

    initial begin
        bus.sha_digest   = 256'd0;
        bus.digest_valid = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_tx", 32'(bus.tx), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.tx_done), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b1;
        tick();

        send_and_check(KNOWN, -1, "known", fr0);
        check("known_first_frame", 32'(fr0), 32'(FIRST_FRAME));

        // Back-to-back capture plus a stray strobe carrying digest 0 during frame 5.
        rand_digest(d);
        send_and_check(d, 5 * FRAME + 2 * CPB + 1, "ovr_mid", fr0);

        // Strobe in the tx_done cycle is an overrun and must not start a new transmission.
        rand_digest(d);
        send_and_check(d, TOTAL - 1, "ovr_done", fr0);
        idle_bad = 0;
        for (int j = 0; j < 2 * FRAME; j++) begin
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_bad++;
            tick();
        end
        check("ovr_done_idle", 32'(idle_bad), 32'd0);

        // Reset during the data bits of frame 3.
        rand_digest(d);
        bus.sha_digest   = d;
        bus.digest_valid = 1'b1;
        tick();
        bus.digest_valid = 1'b0;
        for (int j = 0; j < 3 * FRAME + 4 * CPB + 1; j++) tick();
        rst = 1'b0;
        tick();
        check("midrst_tx", 32'(bus.tx), 32'd1);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.tx_done), 32'd0);
        rst = 1'b1;
        idle_bad   = 0;
        stray_done = 0;
        for (int j = 0; j < TOTAL; j++) begin
            if (bus.tx_done === 1'b1) stray_done++;
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) idle_bad++;
            tick();
        end
        check("midrst_no_done", 32'(stray_done), 32'd0);
        check("midrst_idle", 32'(idle_bad), 32'd0);

        rand_digest(d);
        send_and_check(d, -1, "after_rst", fr0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
